// File: rtl/entry_alloc_tracker_if.sv
//==============================================================================
// Module      : entry_alloc_tracker_if
// Description : Allocation / release / status bundle for entry_alloc_tracker.
//               slave  : the tracker (drives grant, id and status)
//               master : the requester (drives alloc_req and release)
//               Ports  : alloc_req, alloc_gnt, alloc_id, rel_valid, rel_id,
//                        busy, count, full, empty, rel_err
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface entry_alloc_tracker_if #(
    parameter int NUM_ENTRIES = 8
);
    localparam int ID_W  = (NUM_ENTRIES < 2) ? 1 : $clog2(NUM_ENTRIES);
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

    logic                   alloc_req;
    logic                   alloc_gnt;
    logic [ID_W-1:0]        alloc_id;
    logic                   rel_valid;
    logic [ID_W-1:0]        rel_id;
    logic [NUM_ENTRIES-1:0] busy;
    logic [CNT_W-1:0]       count;
    logic                   full;
    logic                   empty;
    logic                   rel_err;

    modport slave (
        input  alloc_req, rel_valid, rel_id,
        output alloc_gnt, alloc_id, busy, count, full, empty, rel_err
    );

    modport master (
        output alloc_req, rel_valid, rel_id,
        input  alloc_gnt, alloc_id, busy, count, full, empty, rel_err
    );
endinterface

`default_nettype wire

// File: rtl/entry_alloc_tracker.sv
//==============================================================================
// Module      : entry_alloc_tracker
// Description : Busy/free tracker for NUM_ENTRIES miss-handling slots. Grants
//               the highest-index free entry combinationally, accepts one
//               release per cycle, flags illegal releases one cycle later.
//               Ports  : clk, rst (sync, active-high), bus (slave modport)
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module entry_alloc_tracker #(
    parameter int NUM_ENTRIES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    entry_alloc_tracker_if.slave  bus
);
    localparam int ID_W  = (NUM_ENTRIES < 2) ? 1 : $clog2(NUM_ENTRIES);
    localparam int CNT_W = $clog2(NUM_ENTRIES + 1);

    generate
        if (NUM_ENTRIES < 2) begin : g_param_check
            $fatal(1, "entry_alloc_tracker: NUM_ENTRIES must be >= 2");
        end
    endgenerate

    logic [NUM_ENTRIES-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   full_q, full_d;
    logic                   empty_q, empty_d;
    logic                   rel_err_q;

    logic                   w_gnt;
    logic [ID_W-1:0]        w_alloc_id;
    logic [NUM_ENTRIES-1:0] w_alloc_mask;
    logic [NUM_ENTRIES-1:0] w_rel_mask;
    logic                   w_rel_legal;
    logic                   w_rel_err;

    // Ascending scan: the last free index seen wins, giving the highest one.
    always_comb begin
        w_alloc_id = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (!busy_q[i]) begin
                w_alloc_id = ID_W'(i);
            end
        end
    end

    // Full is registered, so a same-cycle release can never enable a grant.
    assign w_gnt = bus.alloc_req & ~full_q & ~rst;

    // Release decode by per-entry match: ids beyond NUM_ENTRIES-1 match no
    // entry, so range and busy checks fall out of the same comparison.
    always_comb begin
        w_alloc_mask = '0;
        w_rel_mask   = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            w_alloc_mask[i] = w_gnt && (w_alloc_id == ID_W'(i));
            w_rel_mask[i]   = bus.rel_valid && (bus.rel_id == ID_W'(i)) && busy_q[i];
        end
    end

    assign w_rel_legal = |w_rel_mask;
    assign w_rel_err   = bus.rel_valid & ~w_rel_legal;

    // Allocation targets a free entry and release a busy one, so the two
    // masks never overlap.
    always_comb begin
        busy_d  = (busy_q | w_alloc_mask) & ~w_rel_mask;
        count_d = count_q + CNT_W'(w_gnt) - CNT_W'(w_rel_legal);
        full_d  = (count_d == CNT_W'(NUM_ENTRIES));
        empty_d = (count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            rel_err_q <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            rel_err_q <= w_rel_err;
        end
    end

    assign bus.alloc_gnt = w_gnt;
    assign bus.alloc_id  = w_alloc_id;
    assign bus.busy      = busy_q;
    assign bus.count     = count_q;
    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.rel_err   = rel_err_q;

endmodule

`default_nettype wire

// File: tb/tb_entry_alloc_tracker.sv
//==============================================================================
// Module      : tb_entry_alloc_tracker
// Description : Self-checking bench for entry_alloc_tracker (8 and 6 entries).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_entry_alloc_tracker;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    entry_alloc_tracker_if #(.NUM_ENTRIES(8)) bus8 ();
    entry_alloc_tracker_if #(.NUM_ENTRIES(6)) bus6 ();

    entry_alloc_tracker #(.NUM_ENTRIES(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8.slave));
    entry_alloc_tracker #(.NUM_ENTRIES(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6.slave));

    typedef struct {
        logic       gnt;
        logic [2:0] id;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;

    // Inputs change 1 time unit after a posedge; comb outputs are sampled
    // 1 unit later; registered outputs 1 unit after the next posedge.
    task automatic drive(input logic areq, input logic rv, input logic [2:0] rid);
        bus8.alloc_req = areq;
        bus8.rel_valid = rv;
        bus8.rel_id    = rid;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus6.alloc_req = 1'b0; bus6.rel_valid = 1'b0; bus6.rel_id = 3'd0;
        drive(1'b1, 1'b0, 3'd0);
        for (int c = 0; c < 2; c++) begin
            tick();
            total++;
            if (bus8.alloc_gnt !== 1'b0) begin
                bad++; $display("FAIL reset_gnt: got %b want 0", bus8.alloc_gnt);
            end
        end
        total++;
        if (bus8.busy !== 8'h00 || bus8.count !== 4'd0 || bus8.empty !== 1'b1 ||
            bus8.full !== 1'b0 || bus8.rel_err !== 1'b0) begin
            bad++; $display("FAIL reset_state: busy=%h cnt=%0d empty=%b full=%b err=%b want 00 0 1 0 0",
                            bus8.busy, bus8.count, bus8.empty, bus8.full, bus8.rel_err);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'd0);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b0, 3'd0);
            sbq.push_back('{gnt: (i < 8), id: 3'(7 - i)});
            e = sbq.pop_front();
            total++;
            if (bus8.alloc_gnt !== e.gnt || (e.gnt && bus8.alloc_id !== e.id)) begin
                bad++; $display("FAIL fill_grant[%0d]: got gnt=%b id=%0d want gnt=%b id=%0d",
                                i, bus8.alloc_gnt, bus8.alloc_id, e.gnt, e.id);
            end
            tick();
        end
        drive(1'b0, 1'b0, 3'd0);
        total++;
        if (bus8.busy !== 8'hFF || bus8.count !== 4'd8 || bus8.full !== 1'b1 || bus8.empty !== 1'b0) begin
            bad++; $display("FAIL fill_state: busy=%h cnt=%0d full=%b empty=%b want ff 8 1 0",
                            bus8.busy, bus8.count, bus8.full, bus8.empty);
        end
    endtask

    task automatic test_release_realloc();
        // Release while full together with a request: no grant that cycle.
        drive(1'b1, 1'b1, 3'd3);
        sbq.push_back('{gnt: 1'b0, id: 3'd0});
        e = sbq.pop_front();
        total++;
        if (bus8.alloc_gnt !== e.gnt) begin
            bad++; $display("FAIL full_rel_gnt: got %b want 0", bus8.alloc_gnt);
        end
        tick();
        drive(1'b0, 1'b0, 3'd0);
        total++;
        if (bus8.busy !== 8'hF7 || bus8.count !== 4'd7 || bus8.full !== 1'b0) begin
            bad++; $display("FAIL rel3_state: busy=%h cnt=%0d full=%b want f7 7 0",
                            bus8.busy, bus8.count, bus8.full);
        end
        drive(1'b1, 1'b0, 3'd0);
        sbq.push_back('{gnt: 1'b1, id: 3'd3});
        e = sbq.pop_front();
        total++;
        if (bus8.alloc_gnt !== e.gnt || bus8.alloc_id !== e.id) begin
            bad++; $display("FAIL realloc3: got gnt=%b id=%0d want gnt=1 id=3", bus8.alloc_gnt, bus8.alloc_id);
        end
        tick();
        drive(1'b0, 1'b0, 3'd0);
        total++;
        if (bus8.busy !== 8'hFF || bus8.full !== 1'b1) begin
            bad++; $display("FAIL refill: busy=%h full=%b want ff 1", bus8.busy, bus8.full);
        end
    endtask

    task automatic test_simul_alloc_release();
        for (int r = 7; r >= 4; r--) begin
            drive(1'b0, 1'b1, 3'(r));
            tick();
        end
        drive(1'b0, 1'b0, 3'd0);
        total++;
        if (bus8.busy !== 8'h0F || bus8.count !== 4'd4) begin
            bad++; $display("FAIL setup_0f: busy=%h cnt=%0d want 0f 4", bus8.busy, bus8.count);
        end
        drive(1'b1, 1'b1, 3'd2);
        sbq.push_back('{gnt: 1'b1, id: 3'd7});
        e = sbq.pop_front();
        total++;
        if (bus8.alloc_gnt !== e.gnt || bus8.alloc_id !== e.id) begin
            bad++; $display("FAIL simul_grant: got gnt=%b id=%0d want gnt=1 id=7", bus8.alloc_gnt, bus8.alloc_id);
        end
        tick();
        drive(1'b0, 1'b0, 3'd0);
        total++;
        if (bus8.busy !== 8'h8B || bus8.count !== 4'd4 || bus8.rel_err !== 1'b0) begin
            bad++; $display("FAIL simul_state: busy=%h cnt=%0d err=%b want 8b 4 0",
                            bus8.busy, bus8.count, bus8.rel_err);
        end
    endtask

    task automatic test_illegal_release();
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, (k == 0) ? 3'd7 : (k == 1) ? 3'd3 : 3'd1);
            tick();
        end
        drive(1'b0, 1'b1, 3'd5);
        total++;
        if (bus8.busy !== 8'h01) begin
            bad++; $display("FAIL setup_01: busy=%h want 01", bus8.busy);
        end
        tick();
        drive(1'b0, 1'b0, 3'd0);
        total++;
        if (bus8.busy !== 8'h01 || bus8.rel_err !== 1'b1 || bus8.count !== 4'd1) begin
            bad++; $display("FAIL illegal_rel: busy=%h err=%b cnt=%0d want 01 1 1",
                            bus8.busy, bus8.rel_err, bus8.count);
        end
        tick();
        total++;
        if (bus8.rel_err !== 1'b0) begin
            bad++; $display("FAIL rel_err_pulse: got %b want 0", bus8.rel_err);
        end
        // Release of the very entry being allocated: illegal, allocation holds.
        drive(1'b1, 1'b1, 3'd7);
        sbq.push_back('{gnt: 1'b1, id: 3'd7});
        e = sbq.pop_front();
        total++;
        if (bus8.alloc_gnt !== e.gnt || bus8.alloc_id !== e.id) begin
            bad++; $display("FAIL self_rel_grant: got gnt=%b id=%0d want 1 7", bus8.alloc_gnt, bus8.alloc_id);
        end
        tick();
        drive(1'b0, 1'b0, 3'd0);
        total++;
        if (bus8.busy !== 8'h81 || bus8.count !== 4'd2 || bus8.rel_err !== 1'b1) begin
            bad++; $display("FAIL self_rel_state: busy=%h cnt=%0d err=%b want 81 2 1",
                            bus8.busy, bus8.count, bus8.rel_err);
        end
        // Out-of-range id on the 6-entry instance.
        bus6.rel_valid = 1'b1; bus6.rel_id = 3'd7;
        tick();
        bus6.rel_valid = 1'b0; bus6.rel_id = 3'd0;
        total++;
        if (bus6.rel_err !== 1'b1 || bus6.busy !== 6'h00 || bus6.empty !== 1'b1) begin
            bad++; $display("FAIL n6_oor_rel: err=%b busy=%h empty=%b want 1 00 1",
                            bus6.rel_err, bus6.busy, bus6.empty);
        end
    endtask

    task automatic test_reset_mid();
        // 81 -> release 0 + alloc 6 -> C0 -> alloc 5 -> E0 -> alloc 4 -> F0
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, (k == 0), 3'd0);
            sbq.push_back('{gnt: 1'b1, id: 3'(6 - k)});
            e = sbq.pop_front();
            total++;
            if (bus8.alloc_gnt !== e.gnt || bus8.alloc_id !== e.id) begin
                bad++; $display("FAIL mid_alloc[%0d]: got gnt=%b id=%0d want 1 %0d",
                                k, bus8.alloc_gnt, bus8.alloc_id, e.id);
            end
            tick();
        end
        drive(1'b0, 1'b0, 3'd0);
        total++;
        if (bus8.busy !== 8'hF0 || bus8.count !== 4'd4) begin
            bad++; $display("FAIL setup_f0: busy=%h cnt=%0d want f0 4", bus8.busy, bus8.count);
        end
        rst = 1'b1;
        drive(1'b1, 1'b0, 3'd0);
        total++;
        if (bus8.alloc_gnt !== 1'b0) begin
            bad++; $display("FAIL mid_rst_gnt: got %b want 0", bus8.alloc_gnt);
        end
        tick();
        total++;
        if (bus8.busy !== 8'h00 || bus8.count !== 4'd0 || bus8.empty !== 1'b1 || bus8.full !== 1'b0) begin
            bad++; $display("FAIL mid_rst_state: busy=%h cnt=%0d empty=%b full=%b want 00 0 1 0",
                            bus8.busy, bus8.count, bus8.empty, bus8.full);
        end
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'd0);
        tick();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_release_realloc();
        test_simul_alloc_release();
        test_illegal_release();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
